// File: rtl/adc_capture_buffer.sv
// adc_capture_buffer: triggered ADC sample capture with valid/ready readout. Rev 1.0
// Optional build macro ADC_CAPTURE_AVG_EN stores the mean of 4 raw samples per word.
`default_nettype none

module adc_capture_buffer #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       sample_clk,
  input  logic [7:0] sample_in,
  input  logic       arm,
  input  logic       abort,
  input  logic       force_trig,
  input  logic [7:0] trig_level,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_READOUT = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);

  state_t              r_state, w_state_n;
  logic                r_sclk_meta, r_sclk_sync, r_sclk_prev;
  logic [ADDR_W-1:0]   r_wr_ptr, w_wr_ptr_n;
  logic [ADDR_W-1:0]   r_rd_ptr, w_rd_ptr_n;
  logic [7:0]          r_prev, w_prev_n;
  logic                r_prev_vld, w_prev_vld_n;
  logic                r_out_valid, w_out_valid_n;
  logic                r_done, w_done_n;
  logic [7:0]          r_out_data;
  logic [7:0]          r_mem [DEPTH];
  logic                w_we;
  logic [ADDR_W-1:0]   w_waddr;
  logic [7:0]          w_wdata;
  logic                w_stb, w_cross, w_accept;
  logic [ADDR_W-1:0]   w_rd_addr;
`ifdef ADC_CAPTURE_AVG_EN
  logic [9:0]          r_acc, w_acc_n;
  logic [1:0]          r_cnt, w_cnt_n;
  logic [9:0]          w_sum;

  assign w_sum = r_acc + {2'b00, sample_in};
`endif

  // sample_clk is asynchronous to CLK; only its synchronised rising edge is used
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      r_sclk_meta <= 1'b0;
      r_sclk_sync <= 1'b0;
      r_sclk_prev <= 1'b0;
    end else begin
      r_sclk_meta <= sample_clk;
      r_sclk_sync <= r_sclk_meta;
      r_sclk_prev <= r_sclk_sync;
    end
  end

  assign w_stb     = r_sclk_sync & ~r_sclk_prev;
  assign w_cross   = r_prev_vld && (r_prev < trig_level) && (sample_in >= trig_level);
  assign w_accept  = r_out_valid & out_ready;
  assign w_rd_addr = w_accept ? r_rd_ptr + 1'b1 : r_rd_ptr;

  always_comb begin
    w_state_n     = r_state;
    w_wr_ptr_n    = r_wr_ptr;
    w_rd_ptr_n    = r_rd_ptr;
    w_prev_n      = r_prev;
    w_prev_vld_n  = r_prev_vld;
    w_out_valid_n = r_out_valid;
    w_done_n      = 1'b0;
    w_we          = 1'b0;
    w_waddr       = r_wr_ptr;
    w_wdata       = sample_in;
`ifdef ADC_CAPTURE_AVG_EN
    w_acc_n       = r_acc;
    w_cnt_n       = r_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (arm) begin
          w_state_n    = S_ARMED;
          w_prev_vld_n = 1'b0;
        end
      end
      S_ARMED: begin
        if (w_stb) begin
          w_prev_n     = sample_in;
          w_prev_vld_n = 1'b1;
        end
        if (w_stb && w_cross) begin
          w_state_n  = S_CAPTURE;
`ifdef ADC_CAPTURE_AVG_EN
          w_acc_n    = {2'b00, sample_in};
          w_cnt_n    = 2'd1;
          w_wr_ptr_n = '0;
`else
          w_we       = 1'b1;
          w_waddr    = '0;
          w_wr_ptr_n = ADDR_W'(1);
`endif
        end else if (force_trig) begin
          // the next strobed sample becomes word 0
          w_state_n  = S_CAPTURE;
          w_wr_ptr_n = '0;
`ifdef ADC_CAPTURE_AVG_EN
          w_acc_n    = '0;
          w_cnt_n    = 2'd0;
`endif
        end
      end
      S_CAPTURE: begin
        if (w_stb) begin
`ifdef ADC_CAPTURE_AVG_EN
          if (r_cnt == 2'd3) begin
            w_we       = 1'b1;
            w_wdata    = w_sum[9:2];
            w_acc_n    = '0;
            w_cnt_n    = 2'd0;
            w_wr_ptr_n = r_wr_ptr + 1'b1;
            if (r_wr_ptr == c_LAST) w_state_n = S_READOUT;
          end else begin
            w_acc_n = w_sum;
            w_cnt_n = r_cnt + 1'b1;
          end
`else
          w_we       = 1'b1;
          w_wr_ptr_n = r_wr_ptr + 1'b1;
          if (r_wr_ptr == c_LAST) w_state_n = S_READOUT;
`endif
        end
      end
      S_READOUT: begin
        if (!r_out_valid) begin
          w_out_valid_n = 1'b1;
        end else if (w_accept) begin
          if (r_rd_ptr == c_LAST) begin
            w_out_valid_n = 1'b0;
            w_done_n      = 1'b1;
            w_rd_ptr_n    = '0;
            w_state_n     = S_IDLE;
          end else begin
            w_rd_ptr_n = r_rd_ptr + 1'b1;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    if (abort) begin
      w_state_n     = S_IDLE;
      w_out_valid_n = 1'b0;
      w_wr_ptr_n    = '0;
      w_rd_ptr_n    = '0;
      w_done_n      = 1'b0;
      w_we          = 1'b0;
`ifdef ADC_CAPTURE_AVG_EN
      w_acc_n       = '0;
      w_cnt_n       = 2'd0;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_prev      <= '0;
      r_prev_vld  <= 1'b0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
`ifdef ADC_CAPTURE_AVG_EN
      r_acc       <= '0;
      r_cnt       <= 2'd0;
`endif
    end else begin
      r_state     <= w_state_n;
      r_wr_ptr    <= w_wr_ptr_n;
      r_rd_ptr    <= w_rd_ptr_n;
      r_prev      <= w_prev_n;
      r_prev_vld  <= w_prev_vld_n;
      r_out_valid <= w_out_valid_n;
      r_done      <= w_done_n;
`ifdef ADC_CAPTURE_AVG_EN
      r_acc       <= w_acc_n;
      r_cnt       <= w_cnt_n;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  // RAM output register doubles as out_data; it only advances during readout so it holds under backpressure
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      r_out_data <= '0;
    end else if (r_state == S_READOUT) begin
      r_out_data <= r_mem[w_rd_addr];
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_adc_capture_buffer.sv
// tb_adc_capture_buffer: scoreboard bench for adc_capture_buffer. Rev 1.0
`default_nettype none

module tb_adc_capture_buffer;

  localparam int DEPTH = 256;

  logic       CLK = 1'b0;
  logic       RST_n = 1'b0;
  logic       sample_clk = 1'b0;
  logic [7:0] sample_in = 8'h00;
  logic       arm = 1'b0;
  logic       abort = 1'b0;
  logic       force_trig = 1'b0;
  logic [7:0] trig_level = 8'h80;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       busy;
  logic       done;

  int compared = 0;
  int mismatched = 0;
  int pat_mode = 0;
  int samp_idx = 0;
  logic [7:0] exp_q[$];

  adc_capture_buffer #(.DEPTH(DEPTH), .ADDR_W(8)) dut (
    .CLK(CLK), .RST_n(RST_n), .sample_clk(sample_clk), .sample_in(sample_in),
    .arm(arm), .abort(abort), .force_trig(force_trig), .trig_level(trig_level),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] pat(input int mode, input int n);
    logic [7:0] tbl [4];
    logic [1:0] sel;
    tbl = '{8'd10, 8'd20, 8'd30, 8'd41};
    sel = n[1:0];
    case (mode)
      0:       return 8'(n);
      1:       return 8'h40;
      default: return tbl[sel];
    endcase
  endfunction

  function automatic logic [7:0] exp_word(input int mode, input int start, input int k);
`ifdef ADC_CAPTURE_AVG_EN
    logic [9:0] s;
    s = '0;
    for (int i = 0; i < 4; i++) s = s + {2'b00, pat(mode, start + 4 * k + i)};
    return s[9:2];
`else
    return pat(mode, start + k);
`endif
  endfunction

  // front-end model: 6-CLK sample period, data changes with the sample_clk rise
  initial begin
    forever begin
      repeat (3) @(posedge CLK);
      #1;
      sample_clk = 1'b1;
      sample_in  = pat(pat_mode, samp_idx);
      samp_idx++;
      repeat (3) @(posedge CLK);
      #1;
      sample_clk = 1'b0;
    end
  end

  task automatic pulse_arm();
    @(posedge CLK); #1 arm = 1'b1;
    @(posedge CLK); #1 arm = 1'b0;
  endtask

  task automatic pulse_abort();
    @(posedge CLK); #1 abort = 1'b1;
    @(posedge CLK); #1 abort = 1'b0;
  endtask

  task automatic pulse_force();
    @(posedge CLK); #1 force_trig = 1'b1;
    @(posedge CLK); #1 force_trig = 1'b0;
  endtask

  task automatic wait_sample(input logic [7:0] v);
    int i;
    i = 0;
    while (sample_in !== v && i < 3000) begin
      @(posedge CLK);
      i++;
    end
    #1;
    compared++;
    if (sample_in !== v) begin
      mismatched++;
      $display("FAIL wait_sample: sample_in=%h required %h", sample_in, v);
    end
  endtask

  // pops the scoreboard on every accepted word; checks hold-stability and done timing
  task automatic run_readout(input int period, input int n_words, input string tag);
    int cyc, got;
    bit hold, early;
    logic [7:0] held, e;
    cyc = 0; got = 0; hold = 0; early = 0; held = '0;
    out_ready = (period == 1);
    while (got < n_words && cyc < 12000) begin
      @(negedge CLK);
      cyc++;
      if (done) early = 1;
      if (hold) begin
        compared++;
        if (!out_valid || out_data !== held) begin
          mismatched++;
          $display("FAIL %s_hold: valid=%b data=%h required valid=1 data=%h", tag, out_valid, out_data, held);
        end
      end
      hold = 0;
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        compared++;
        if (out_data !== e) begin
          mismatched++;
          $display("FAIL %s_word%0d: data=%h required %h", tag, got, out_data, e);
        end
        got++;
      end else if (out_valid) begin
        hold = 1;
        held = out_data;
      end
      @(posedge CLK); #1;
      out_ready = (period == 1) || ((cyc % period) == 0);
    end
    compared++;
    if (got < n_words) begin
      mismatched++;
      $display("FAIL %s_timeout: words=%0d required %0d", tag, got, n_words);
      exp_q.delete();
    end
    if (n_words == DEPTH) begin
      @(negedge CLK);
      compared++;
      if (done !== 1'b1 || early) begin
        mismatched++;
        $display("FAIL %s_done: done=%b early=%0d required done=1 early=0", tag, done, early);
      end
      @(negedge CLK);
      compared++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        mismatched++;
        $display("FAIL %s_end: valid=%b busy=%b done=%b required 0 0 0", tag, out_valid, busy, done);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    RST_n = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: %b required 0", out_valid); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: %b required 0", busy); end
    compared++;
    if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done: %b required 0", done); end
    compared++;
    if (out_data !== 8'h00) begin mismatched++; $display("FAIL reset_data: %h required 00", out_data); end
    @(posedge CLK); #1 RST_n = 1'b1;
  endtask

  task automatic test_ramp_capture(input int period, input string tag);
    pat_mode = 0;
    trig_level = 8'h80;
    for (int k = 0; k < DEPTH; k++) exp_q.push_back(exp_word(0, 128, k));
    pulse_arm();
    @(negedge CLK);
    compared++;
    if (busy !== 1'b1) begin mismatched++; $display("FAIL %s_busy: %b required 1", tag, busy); end
    run_readout(period, DEPTH, tag);
  endtask

  task automatic test_force_trigger();
    pat_mode = 1;
    trig_level = 8'h80;
    repeat (2) @(posedge sample_clk);
    pulse_arm();
    repeat (1000) @(posedge sample_clk);
    @(negedge CLK);
    compared++;
    if (busy !== 1'b1) begin mismatched++; $display("FAIL armed_busy: %b required 1", busy); end
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL armed_valid: %b required 0", out_valid); end
    for (int k = 0; k < DEPTH; k++) exp_q.push_back(exp_word(1, 0, k));
    pulse_force();
    run_readout(1, DEPTH, "force");
  endtask

  task automatic test_abort();
    bit seen;
    pat_mode = 0;
    trig_level = 8'h80;
    wait_sample(8'h10);
    pulse_arm();
    wait_sample(8'h80);
    repeat (100) @(posedge sample_clk);
    pulse_abort();
    @(negedge CLK);
    compared++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_idle: busy=%b valid=%b required 0 0", busy, out_valid);
    end
    seen = (done === 1'b1);
    repeat (60) begin
      @(negedge CLK);
      if (done === 1'b1) seen = 1;
    end
    compared++;
    if (seen) begin mismatched++; $display("FAIL abort_done: done seen=1 required 0"); end
  endtask

  task automatic test_reset_readout();
    pat_mode = 0;
    trig_level = 8'h80;
    for (int k = 0; k < DEPTH; k++) exp_q.push_back(exp_word(0, 128, k));
    pulse_arm();
    run_readout(3, 50, "pre_rst");
    @(posedge CLK); #1 RST_n = 1'b0;
    @(posedge CLK); #1 RST_n = 1'b1;
    @(negedge CLK);
    compared++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00) begin
      mismatched++;
      $display("FAIL rst_readout: valid=%b busy=%b data=%h required 0 0 00", out_valid, busy, out_data);
    end
    exp_q.delete();
  endtask

`ifdef ADC_CAPTURE_AVG_EN
  task automatic test_average();
    pat_mode = 2;
    repeat (2) @(posedge sample_clk);
    pulse_arm();
    for (int k = 0; k < DEPTH; k++) exp_q.push_back(exp_word(2, 0, k));
    pulse_force();
    run_readout(1, DEPTH, "avg");
  endtask
`endif

  initial begin
    test_reset();
    test_ramp_capture(1, "ramp");
    test_force_trigger();
    test_ramp_capture(3, "backpressure");
    test_abort();
    test_ramp_capture(1, "after_abort");
    test_reset_readout();
    test_ramp_capture(1, "after_reset");
`ifdef ADC_CAPTURE_AVG_EN
    test_average();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
